// File: rtl/apb_master_nslv_if.sv
// Request/response port and APB bus of the multi-slave APB4 master.
// The master modport is the bridge side; slave is the front end plus the APB slaves.
interface apb_master_nslv_if #(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
);
   logic                         req_valid;
   logic                         req_ready;
   logic                         req_write;
   logic [ADDR_W-1:0]            req_addr;
   logic [DATA_W-1:0]            req_wdata;
   logic [DATA_W/8-1:0]          req_strb;
   logic [2:0]                   req_prot;
   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [DATA_W-1:0]            rsp_rdata;
   logic                         rsp_err;
   logic [ADDR_W-1:0]            PADDR;
   logic [2:0]                   PPROT;
   logic [NUM_SLAVES-1:0]        PSELx;
   logic                         PENABLE;
   logic                         PWRITE;
   logic [DATA_W-1:0]            PWDATA;
   logic [DATA_W/8-1:0]          PSTRB;
   logic [NUM_SLAVES-1:0]        PREADY;
   logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]        PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, rsp_ready,
             PREADY, PRDATA, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, rsp_ready,
             PREADY, PRDATA, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB
   );
endinterface

// File: rtl/apb_master_nslv.sv
// APB4 master bridging one valid/ready request port onto NUM_SLAVES APB slaves.
// Define APB_TIMEOUT_EN to abort ACCESS phases longer than TIMEOUT_CYCLES.
module apb_master_nslv #(
   parameter int NUM_SLAVES     = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int SLV_ADDR_LSB   = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   apb_master_nslv_if.master bus,
   output logic [1:0]        Out_State
);
   localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [SEL_W-1:0]      req_idx;
   logic [SEL_W-1:0]      idx;
   logic                  req_dec_err;
   logic                  accept;
   logic                  timeout;
   logic [NUM_SLAVES-1:0] sel_vec;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_W-1:0]     sel_rdata;

   logic [ADDR_W-1:0]     paddr_q;
   logic [2:0]            pprot_q;
   logic                  pwrite_q;
   logic [DATA_W-1:0]     pwdata_q;
   logic [STRB_W-1:0]     pstrb_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic                  rsp_err_q;

   assign req_idx     = bus.req_addr[SLV_ADDR_LSB +: SEL_W];
   assign req_dec_err = (32'(req_idx) >= NUM_SLAVES);
   assign accept      = (state == IDLE) && bus.req_valid;

   // Unselected slaves never reach the response path.
   always_comb begin
      sel_vec   = '0;
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (idx == SEL_W'(i)) begin
            sel_vec[i] = 1'b1;
            sel_ready  = bus.PREADY[i];
            sel_err    = bus.PSLVERR[i];
            sel_rdata  = bus.PRDATA[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         wait_cnt <= '0;
      else if (state != ACCESS)
         wait_cnt <= '0;
      else if (!sel_ready)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout = (state == ACCESS) && !sel_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.PSELx     = '0;
      bus.PENABLE   = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_nxt = req_dec_err ? RESP : SETUP;
         end
         SETUP: begin
            bus.PSELx = sel_vec;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            bus.PSELx   = sel_vec;
            bus.PENABLE = 1'b1;
            if (sel_ready || timeout)
               state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus fields are loaded only on accept, so they stay stable through the transfer and after it.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         paddr_q     <= '0;
         pprot_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         idx         <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (accept) begin
         paddr_q  <= bus.req_addr;
         pprot_q  <= bus.req_prot;
         pwrite_q <= bus.req_write;
         pwdata_q <= bus.req_wdata;
         pstrb_q  <= bus.req_write ? bus.req_strb : '0;
         idx      <= req_idx;
         if (req_dec_err) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
         end
      end else if (state == ACCESS) begin
         if (sel_ready) begin
            rsp_rdata_q <= pwrite_q ? '0 : sel_rdata;
            rsp_err_q   <= sel_err;
         end else if (timeout) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
         end
      end
   end

   assign bus.PADDR     = paddr_q;
   assign bus.PPROT     = pprot_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.PSTRB     = pstrb_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign Out_State     = state;
endmodule

// File: tb/tb_apb_master_nslv.sv
// Randomised bench for apb_master_nslv with three slaves, so index 3 is a decode error.
// Expected cycle-by-cycle state comes from the transfer's wait count, not from the DUT.
module tb_apb_master_nslv;
   localparam int NS  = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LSB = 12;
   localparam int TO  = 16;
`ifdef APB_TIMEOUT_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic [1:0] Out_State;
   int         n_tests = 0;
   int         n_fail = 0;

   apb_master_nslv_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_master_nslv #(
      .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
      .SLV_ADDR_LSB(LSB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .bus(bus),
      .Out_State(Out_State)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete transfer; rst_at>0 pulls reset in that cycle after accept.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int waits,
                       input bit serr, input int rdelay, input int rst_at);
      int unsigned   idx;
      bit            dec, abort, done;
      int            acc, resp_k, k, rcnt;
      logic [1:0]    exp_state;
      logic [NS-1:0] exp_sel;
      logic [31:0]   sdata [NS];
      logic [31:0]   exp_rdata;
      logic [3:0]    exp_strb;
      bit            exp_err;

      idx    = 32'(addr[LSB +: 2]);
      dec    = idx >= NS;
      abort  = TEN && !dec && (waits >= TO);
      acc    = abort ? TO : waits + 1;
      resp_k = dec ? 1 : acc + 2;
      for (int i = 0; i < NS; i++) begin
         sdata[i] = $urandom;
         bus.PRDATA[i*DW +: DW] = sdata[i];
      end
      exp_err   = dec || abort || serr;
      exp_rdata = (dec || abort || wr) ? 32'h0 : sdata[idx];
      exp_strb  = wr ? strb : 4'h0;

      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_strb  = strb;
      bus.req_prot  = prot;
      bus.rsp_ready = 1'b0;
      check("req_ready_idle", bus.req_ready, 1);
      check("state_idle", Out_State, 0);
      @(posedge PCLK); #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_strb  = 4'($urandom);
      bus.req_prot  = 3'($urandom);

      k = 1; rcnt = 0; done = 1'b0;
      while (!done && k < 400) begin
         exp_state = (k >= resp_k) ? 2'd3 : ((k == 1) ? 2'd1 : 2'd2);
         if (rst_at == k) begin
            #2 PRESETn = 1'b0;
            #1;
            check("rst_state", Out_State, 0);
            check("rst_psel", bus.PSELx, 0);
            check("rst_penable", bus.PENABLE, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_paddr", bus.PADDR, 0);
            check("rst_pwdata", bus.PWDATA, 0);
            check("rst_rsp_err", bus.rsp_err, 0);
            @(posedge PCLK); #1;
            PRESETn = 1'b1;
            bus.PREADY = '0;
            return;
         end
         exp_sel = '0;
         if (!dec && (exp_state == 2'd1 || exp_state == 2'd2)) exp_sel[idx] = 1'b1;
         check("state", Out_State, exp_state);
         check("psel", bus.PSELx, exp_sel);
         check("penable", bus.PENABLE, exp_state == 2'd2);
         check("rsp_valid", bus.rsp_valid, exp_state == 2'd3);
         check("req_ready_busy", bus.req_ready, 0);
         check("paddr", bus.PADDR, addr);
         check("pwrite", bus.PWRITE, wr);
         check("pwdata", bus.PWDATA, wdata);
         check("pstrb", bus.PSTRB, exp_strb);
         check("pprot", bus.PPROT, prot);
         if (exp_state == 2'd3) begin
            check("rsp_rdata", bus.rsp_rdata, exp_rdata);
            check("rsp_err", bus.rsp_err, exp_err);
         end

         bus.PREADY  = NS'($urandom);
         bus.PSLVERR = NS'($urandom);
         if (!dec) begin
            bus.PREADY[idx]  = (exp_state == 2'd2) && (k == waits + 2);
            bus.PSLVERR[idx] = serr;
         end
         if (exp_state == 2'd3) begin
            bus.rsp_ready = (rcnt >= rdelay);
            done = bus.rsp_ready;
            rcnt++;
         end else begin
            bus.rsp_ready = 1'($urandom);
         end
         @(posedge PCLK); #1;
         k++;
      end
      check("xfer_completes", done, 1);
      bus.rsp_ready = 1'b0;
      check("state_back_idle", Out_State, 0);
      check("rsp_valid_dropped", bus.rsp_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_strb  = '0;
      bus.req_prot  = '0;
      bus.rsp_ready = 1'b0;
      bus.PREADY    = '0;
      bus.PRDATA    = '0;
      bus.PSLVERR   = '0;
      repeat (3) @(posedge PCLK);
      #1;
      check("reset_state", Out_State, 0);
      check("reset_psel", bus.PSELx, 0);
      check("reset_penable", bus.PENABLE, 0);
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_paddr", bus.PADDR, 0);
      check("reset_rsp_rdata", bus.rsp_rdata, 0);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      xfer(1'b1, 32'h0000_1040, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 0, 0);
      xfer(1'b0, 32'h0000_2004, 32'h1111_2222, 4'hF, 3'b010, 3, 1'b0, 0, 0);
      xfer(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b001, 0, 1'b1, 0, 0);
      xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 1, 1'b0, 0, 0);
      xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 0, 0);
      xfer(1'b1, 32'h0000_3ABC, 32'h5A5A_5A5A, 4'h3, 3'b111, 0, 1'b0, 2, 0);
      xfer(1'b0, 32'h0000_1010, 32'h0, 4'h0, 3'b000, 1, 1'b0, 5, 0);
      xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000, TO + 4, 1'b0, 0, 0);
      xfer(1'b1, 32'h0000_2020, 32'hCAFE_F00D, 4'hA, 3'b100, TO - 1, 1'b0, 0, 0);
      xfer(1'b1, 32'h0000_2000, 32'h7777_8888, 4'hF, 3'b000, 50, 1'b0, 0, 4);
      xfer(1'b0, 32'h0000_0ffc, 32'h0, 4'h0, 3'b000, 0, 1'b0, 0, 0);

      for (int n = 0; n < 60; n++) begin
         xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 5)), 1'($urandom), int'($urandom_range(0, 3)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
- Parametrised APB4 master bridging a single request/response port (driven by the AXI4-Lite front end) onto NUM_SLAVES APB slaves.
- Decodes the slave index from the address, drives a one-hot PSELx, and muxes PREADY/PRDATA/PSLVERR from the selected slave.
- Returns a registered response through a valid/ready handshake.
- Adds decode-error handling, PSTRB/PPROT pass-through and an optional wait-state timeout.

Parameters:
NUM_SLAVES, 4, number of APB slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SLV_ADDR_LSB, 12, lowest address bit of the slave-index field
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN; must be >=2)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_strb  in  DATA_W/8  write byte strobes
req_prot  in  3  protection attributes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  slave error, decode error or timeout
PADDR  out  ADDR_W  APB address
PPROT  out  3  APB protection
PSELx  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PREADY  in  NUM_SLAVES  per-slave ready
PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
PSLVERR  in  NUM_SLAVES  per-slave error
Out_State  out  2  current state encoding

Behaviour:
- Clocking and reset:
  - One clock, PCLK.
  - PRESETn is asynchronous and active-low. All state and outputs are cleared immediately on assertion: state=IDLE, PSELx=0, PENABLE=0, PADDR/PWDATA/PSTRB/PPROT/PWRITE=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Reset mid-transfer drops the transfer silently.
- States: IDLE=0, SETUP=1, ACCESS=2, RESP=3. Out_State reflects the state register.
- Request acceptance:
  - req_ready = (state==IDLE). It is combinational from state only.
  - On accept, the following are registered: PADDR, PWRITE, PWDATA, PPROT, slave index idx = req_addr[SLV_ADDR_LSB +: SEL_W], where SEL_W = max(1, clog2(NUM_SLAVES)).
  - PSTRB = req_strb for writes and 0 for reads.
- Decode error: if idx >= NUM_SLAVES, IDLE goes directly to RESP with rsp_err=1 and rsp_rdata=0. No PSELx is asserted.
- Otherwise IDLE goes to SETUP.
- SETUP: PSELx[idx]=1, PENABLE=0, lasts exactly one cycle, then ACCESS.
- ACCESS:
  - PSELx[idx]=1, PENABLE=1.
  - On PREADY[idx]=1, the following are captured: rsp_rdata = PRDATA slice idx (read) or 0 (write), rsp_err = PSLVERR[idx]. Then go to RESP.
  - Otherwise stay in ACCESS.
  - PREADY/PSLVERR of unselected slaves are ignored.
- APB stability: PADDR/PWRITE/PWDATA/PSTRB/PPROT are held constant from SETUP through the last ACCESS cycle, and stay at their values until the next accept.
- RESP:
  - PSELx=0, PENABLE=0, rsp_valid=1.
  - rsp_rdata and rsp_err are held until rsp_valid && rsp_ready, then IDLE.
  - rsp_valid never drops without a handshake (except on reset).
- Latency: accept in cycle T, SETUP at T+1, ACCESS at T+2. With zero wait states, rsp_valid is high at T+3. Each wait state adds one cycle. Minimum 4 cycles per transfer; no overlap of transfers.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - If the counter equals TIMEOUT_CYCLES-1 and PREADY[idx]=0, the transfer aborts: go to RESP with rsp_err=1 and rsp_rdata=0; PSELx/PENABLE deassert next cycle.
  - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles. PREADY in the final allowed cycle completes normally.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, zero wait, NUM_SLAVES=4: req addr=0x0000_1040, wdata=0xDEADBEEF, strb=0xF -> PSELx=4'b0010 for 2 cycles; PENABLE high 1 cycle; PWDATA=0xDEADBEEF; rsp_valid at accept+3; rsp_err=0; rsp_rdata=0.
- Read, 3 wait states: addr=0x2004, slave 2 PRDATA=0x12345678, PREADY low 3 ACCESS cycles -> PSTRB=0; ACCESS lasts 4 cycles; rsp_rdata=0x12345678 at accept+6.
- Slave error: read of slave 3 with PREADY=1, PSLVERR=1 -> rsp_err=1. Concurrent PSLVERR=1 on slave 0 during a slave-1 transfer -> rsp_err=0.
- Decode error (NUM_SLAVES=3): addr=0x3000 -> PSELx stays 0; rsp_valid at accept+1; rsp_err=1.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16): PREADY held low -> abort after 16 ACCESS cycles with rsp_err=1. Rerun with PREADY high in the 16th cycle -> normal completion with rsp_err=0.
- Backpressure and reset: rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0. Assert PRESETn low mid-ACCESS -> PSELx/PENABLE/rsp_valid go 0 immediately, Out_State=0.
